fetch_stage: RTL and testbench

- Instruction Fetch stage; producer end of the IF-packet interface consumed by the Decode stage.
- Generates sequential PCs, issues in-order requests to instruction memory, and buffers responses in a small FIFO.
- Presents {pc, instr} packets with valid/stall backpressure; flushes on redirect from Execute.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC generation, in-order imem requests, response FIFO, redirect flush.
// Optional stall performance counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic [63:0] o_if_pkt_data,
   output logic        o_if_pkt_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_perf_stall_cnt
`endif
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = CW + 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } if_pkt_t;

   logic [31:0]   r_pc;
   if_pkt_t       r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_fifo_rd;
   logic [PW-1:0] r_fifo_wr;
   logic [CW-1:0] r_fifo_cnt;
   logic [31:0]   r_tag [FIFO_DEPTH];
   logic [PW-1:0] r_tag_rd;
   logic [PW-1:0] r_tag_wr;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_drop_cnt;

   logic [SW-1:0] w_credit_sum;
   logic          w_req;
   logic          w_grant;
   logic          w_accept;
   logic          w_drop;
   logic          w_rv_live;
   logic          w_pop;
   logic          w_fifo_nonempty;
   logic          w_unused_redirect_lsb;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credit covers live requests, stale responses still to drop, and buffered packets
   assign w_credit_sum    = SW'(r_outstanding) + SW'(r_drop_cnt) + SW'(r_fifo_cnt);
   assign w_req           = !rst && !i_redirect && (w_credit_sum < SW'(FIFO_DEPTH));
   assign w_grant         = w_req && i_imem_gnt;
   assign w_rv_live       = i_imem_rvalid && ((r_drop_cnt != '0) || (r_outstanding != '0));
   assign w_accept        = i_imem_rvalid && (r_drop_cnt == '0) && (r_outstanding != '0) && !i_redirect;
   assign w_drop          = i_imem_rvalid && (r_drop_cnt != '0);
   assign w_fifo_nonempty = (r_fifo_cnt != '0);
   assign w_pop           = o_if_pkt_valid && !i_stall;
   assign w_unused_redirect_lsb = ^i_redirect_pc[1:0];

   assign o_imem_req     = w_req;
   assign o_imem_addr    = r_pc;
   assign o_if_pkt_valid = w_fifo_nonempty && !i_redirect;
   assign o_if_pkt_data  = w_fifo_nonempty ? r_fifo[r_fifo_rd] : 64'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_fifo_rd     <= '0;
         r_fifo_wr     <= '0;
         r_fifo_cnt    <= '0;
         r_tag_rd      <= '0;
         r_tag_wr      <= '0;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else if (i_redirect) begin
         r_pc          <= {i_redirect_pc[31:2], 2'b00};
         r_fifo_rd     <= '0;
         r_fifo_wr     <= '0;
         r_fifo_cnt    <= '0;
         r_tag_rd      <= '0;
         r_tag_wr      <= '0;
         r_outstanding <= '0;
         // Every response still owed becomes stale, minus the one arriving now
         r_drop_cnt    <= CW'(SW'(r_drop_cnt) + SW'(r_outstanding) - SW'(w_rv_live));
      end else begin
         if (w_grant) begin
            r_pc             <= r_pc + 32'd4;
            r_tag[r_tag_wr]  <= r_pc;
            r_tag_wr         <= ptr_inc(r_tag_wr);
         end
         if (w_accept) begin
            r_fifo[r_fifo_wr] <= '{pc: r_tag[r_tag_rd], instr: i_imem_rdata};
            r_fifo_wr         <= ptr_inc(r_fifo_wr);
            r_tag_rd          <= ptr_inc(r_tag_rd);
         end
         if (w_pop) begin
            r_fifo_rd <= ptr_inc(r_fifo_rd);
         end
         if (w_grant && !w_accept) begin
            r_outstanding <= r_outstanding + CW'(1);
         end else if (!w_grant && w_accept) begin
            r_outstanding <= r_outstanding - CW'(1);
         end
         if (w_accept && !w_pop) begin
            r_fifo_cnt <= r_fifo_cnt + CW'(1);
         end else if (!w_accept && w_pop) begin
            r_fifo_cnt <= r_fifo_cnt - CW'(1);
         end
         if (w_drop) begin
            r_drop_cnt <= r_drop_cnt - CW'(1);
         end
      end
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(w_accept && (r_fifo_cnt == CW'(FIFO_DEPTH)) && !w_pop));

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_stall_cnt;

   // Saturating count of cycles a valid packet is held by Decode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall_cnt <= '0;
      end else if (o_if_pkt_valid && i_stall && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
         r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
   end

   assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small in-order instruction memory responder.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        i_stall;
   logic [63:0] o_if_pkt_data;
   logic        o_if_pkt_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] o_perf_stall_cnt;
`endif

   fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .o_imem_req     (o_imem_req),
      .o_imem_addr    (o_imem_addr),
      .i_imem_gnt     (i_imem_gnt),
      .i_imem_rvalid  (i_imem_rvalid),
      .i_imem_rdata   (i_imem_rdata),
      .i_redirect     (i_redirect),
      .i_redirect_pc  (i_redirect_pc),
      .i_stall        (i_stall),
      .o_if_pkt_data  (o_if_pkt_data),
      .o_if_pkt_valid (o_if_pkt_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_perf_stall_cnt (o_perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [63:0] got[$];
   int          got_cyc[$];
   logic [31:0] gnt_log[$];
   int          cyc;
   int          lat;
   int          n_checks;
   int          n_pass;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {16'hBEEF, a[15:0]};
   endfunction

   function automatic logic [63:0] exp_pkt(input logic [31:0] pc);
      return {pc, instr_of(pc)};
   endfunction

   function automatic logic [63:0] pkt_at(input int i);
      if (i < got.size()) return got[i];
      return '1;
   endfunction

   function automatic logic [63:0] gnt_at(input int i);
      if (i < gnt_log.size()) return 64'(gnt_log[i]);
      return '1;
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // One clock: sample handshakes before the edge, then update the memory model after it
   task automatic tick();
      #3;
      if (o_imem_req && i_imem_gnt) begin
         gnt_log.push_back(o_imem_addr);
         mq.push_back('{addr: o_imem_addr, due: cyc + lat});
      end
      if (o_if_pkt_valid && !i_stall) begin
         got.push_back(o_if_pkt_data);
         got_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due == cyc) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = instr_of(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = 32'd0;
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'd0;
      i_stall       = 1'b0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'd0;
      mq.delete();
      tick();
      tick();
      got.delete();
      got_cyc.delete();
      gnt_log.delete();
   endtask

   task automatic wait_valid(input string tag);
      for (int n = 0; n < 20; n++) begin
         if (o_if_pkt_valid) break;
         tick();
      end
      check(tag, 64'(o_if_pkt_valid), 64'd1);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      cyc        = 0;
      lat        = 1;
      i_imem_gnt = 1'b1;

      // Reset values and first sequential fetches
      do_reset();
      #1;
      check("rst_req",   64'(o_imem_req),     64'd0);
      check("rst_addr",  64'(o_imem_addr),    64'd0);
      check("rst_valid", 64'(o_if_pkt_valid), 64'd0);
      check("rst_data",  o_if_pkt_data,       64'd0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_perf",  64'(o_perf_stall_cnt), 64'd0);
`endif
      rst = 1'b0;
      #1;
      check("seq_req0",  64'(o_imem_req),  64'd1);
      check("seq_addr0", 64'(o_imem_addr), 64'd0);
      ticks(4);
      check("seq_pkt0",  pkt_at(0), exp_pkt(32'h0));
      check("seq_pkt1",  pkt_at(1), exp_pkt(32'h4));
      check("seq_b2b",   (got.size() >= 2) ? 64'(got_cyc[1] - got_cyc[0]) : '1, 64'd1);
      check("seq_gnt0",  gnt_at(0), 64'h0);
      check("seq_gnt1",  gnt_at(1), 64'h4);
      check("seq_gnt2",  gnt_at(2), 64'h8);

      // Backpressure: FIFO fills, requests stop, head holds, then drains in order
      do_reset();
      i_stall = 1'b1;
      rst     = 1'b0;
      wait_valid("stall_wait");
      ticks(5);
      #1;
      check("stall_valid", 64'(o_if_pkt_valid), 64'd1);
      check("stall_req",   64'(o_imem_req),     64'd0);
      check("stall_head",  o_if_pkt_data,       exp_pkt(32'h0));
      check("stall_nopop", 64'(got.size()),     64'd0);
      i_stall = 1'b0;
      ticks(10);
      check("drain_pkt0", pkt_at(0), exp_pkt(32'h0));
      check("drain_pkt1", pkt_at(1), exp_pkt(32'h4));
      check("drain_pkt2", pkt_at(2), exp_pkt(32'h8));

      // Redirect with a full FIFO flushes buffered packets
      do_reset();
      i_stall = 1'b1;
      rst     = 1'b0;
      wait_valid("flush_wait");
      ticks(3);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h0000_0400;
      #1;
      check("flush_valid_rd", 64'(o_if_pkt_valid), 64'd0);
      tick();
      i_redirect = 1'b0;
      i_stall    = 1'b0;
      #1;
      check("flush_valid", 64'(o_if_pkt_valid), 64'd0);
      check("flush_addr",  64'(o_imem_addr),    64'h400);
      check("flush_req",   64'(o_imem_req),     64'd1);
      ticks(6);
      check("flush_pkt0", pkt_at(0), exp_pkt(32'h400));

      // Redirect with two requests in flight at latency 3, unaligned target
      lat = 3;
      do_reset();
      rst = 1'b0;
      ticks(2);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h0000_0103;
      #1;
      check("rd3_inflight", 64'(gnt_log.size()), 64'd2);
      check("rd3_req_rd",   64'(o_imem_req),     64'd0);
      tick();
      i_redirect = 1'b0;
      gnt_log.delete();
      #1;
      check("rd3_addr",    64'(o_imem_addr), 64'h100);
      check("rd3_req_cr",  64'(o_imem_req),  64'd0);
      ticks(12);
      check("rd3_gnt0", gnt_at(0), 64'h100);
      check("rd3_pkt0", pkt_at(0), exp_pkt(32'h100));
      check("rd3_pkt1", pkt_at(1), exp_pkt(32'h104));

      // Redirect in the same cycle as a response
      do_reset();
      rst = 1'b0;
      ticks(3);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h0000_0200;
      #1;
      check("rdrv_rvalid_seen", 64'(i_imem_rvalid && o_imem_req == 1'b0), 64'd1);
      tick();
      i_redirect = 1'b0;
      gnt_log.delete();
      #1;
      check("rdrv_req",  64'(o_imem_req),  64'd1);
      check("rdrv_addr", 64'(o_imem_addr), 64'h200);
      ticks(12);
      check("rdrv_pkt0", pkt_at(0), exp_pkt(32'h200));
      check("rdrv_pkt1", pkt_at(1), exp_pkt(32'h204));

      // Redirect while a request waits for grant
      lat        = 1;
      i_imem_gnt = 1'b0;
      do_reset();
      rst = 1'b0;
      ticks(2);
      #1;
      check("hold_req",  64'(o_imem_req),     64'd1);
      check("hold_addr", 64'(o_imem_addr),    64'h0);
      i_redirect    = 1'b1;
      i_redirect_pc = 32'h0000_0300;
      i_imem_gnt    = 1'b1;
      #1;
      check("hold_req_rd", 64'(o_imem_req), 64'd0);
      tick();
      i_redirect = 1'b0;
      #1;
      check("hold_addr_new", 64'(o_imem_addr), 64'h300);
      check("hold_req_new",  64'(o_imem_req),  64'd1);
      ticks(6);
      check("hold_gnt0", gnt_at(0), 64'h300);
      check("hold_pkt0", pkt_at(0), exp_pkt(32'h300));

`ifdef FETCH_PERF_CNT_EN
      // Stall cycle counter and its reset
      do_reset();
      i_stall = 1'b1;
      rst     = 1'b0;
      wait_valid("perf_wait");
      ticks(7);
      #1;
      check("perf_cnt7", 64'(o_perf_stall_cnt), 64'd7);
      do_reset();
      #1;
      check("perf_rst", 64'(o_perf_stall_cnt), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
